// File: rtl/ready_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ready_det_pkg
// Description : Shared definitions for the multi-channel ready detector.
//               Holds the per-channel FSM state encoding and the helper
//               that sizes the qualification counter.
// Revision    : 1.0 - initial release
// ============================================================================
package ready_det_pkg;

    // Per-channel FSM states. Both QUAL_* states are "pending" states:
    // QUAL_H still reports not-ready, QUAL_L still reports ready.
    localparam logic [1:0] ST_LOW    = 2'd0;
    localparam logic [1:0] ST_QUAL_H = 2'd1;
    localparam logic [1:0] ST_HIGH   = 2'd2;
    localparam logic [1:0] ST_QUAL_L = 2'd3;

    // Counter width that can hold max(high_cycles, low_cycles).
    function automatic int ctr_width(input int high_cycles, input int low_cycles);
        int m;
        m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ready_det_channel.sv
`default_nettype none
// ============================================================================
// Module      : ready_det_channel
// Description : One ready-detector channel: input synchroniser, stable-high /
//               stable-low qualification FSM, rise/fall pulses and a
//               saturating glitch (aborted qualification) counter.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_raw               - asynchronous ready level
//               i_clear_glitch      - zero the glitch counter
//               o_ready             - qualified ready (registered)
//               o_rise / o_fall     - one-cycle transition pulses
//               o_glitch_cnt        - aborted-qualification count
// Revision    : 1.0 - initial release
// ============================================================================
module ready_det_channel
    import ready_det_pkg::*;
#(
    parameter int HIGH_CYCLES = 10000,
    parameter int LOW_CYCLES  = 1,
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_W    = 8,
    parameter int CTR_SIZE    = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_raw,
    input  logic                i_clear_glitch,
    output logic                o_ready,
    output logic                o_rise,
    output logic                o_fall,
    output logic [GLITCH_W-1:0] o_glitch_cnt
);

    localparam logic [CTR_SIZE-1:0] c_one       = CTR_SIZE'(1);
    localparam logic [CTR_SIZE-1:0] c_high_last = CTR_SIZE'(HIGH_CYCLES - 1);
    localparam logic [CTR_SIZE-1:0] c_low_last  = CTR_SIZE'(LOW_CYCLES - 1);

    logic                w_s;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CTR_SIZE-1:0] r_cnt;
    logic [CTR_SIZE-1:0] w_cnt_nxt;
    logic                w_bump;
    logic                w_ready_nxt;
    logic                r_ready;
    logic                r_rise;
    logic                r_fall;
    logic [GLITCH_W-1:0] r_glitch;
    logic [GLITCH_W-1:0] w_glitch_nxt;

    // Synchroniser; zero stages means the input is already in clk domain.
    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0] r_sync;
        always_ff @(posedge clk) begin
            if (rst) r_sync <= '0;
            else     r_sync <= SYNC_STAGES'({r_sync, i_raw});
        end
        assign w_s = r_sync[SYNC_STAGES-1];
    end else begin : g_nosync
        assign w_s = i_raw;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bump      = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_s) begin
                    if (HIGH_CYCLES == 1) begin
                        w_state_nxt = ST_HIGH;
                    end else begin
                        w_cnt_nxt   = c_one;
                        w_state_nxt = ST_QUAL_H;
                    end
                end
            end
            ST_QUAL_H: begin
                if (!w_s) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                    w_bump      = 1'b1;
                end else if (r_cnt == c_high_last) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_one;
                end
            end
            ST_HIGH: begin
                if (!w_s) begin
                    if (LOW_CYCLES == 1) begin
                        w_state_nxt = ST_LOW;
                    end else begin
                        w_cnt_nxt   = c_one;
                        w_state_nxt = ST_QUAL_L;
                    end
                end
            end
            default: begin // ST_QUAL_L
                if (w_s) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                    w_bump      = 1'b1;
                end else if (r_cnt == c_low_last) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_one;
                end
            end
        endcase
    end

    // ready is registered from the next-state decode so it tracks the
    // state register exactly while remaining a pure flop output.
    assign w_ready_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_QUAL_L);

    // Clear wins over a same-cycle abort; increments saturate at all-ones.
    always_comb begin
        w_glitch_nxt = r_glitch;
        if (i_clear_glitch)
            w_glitch_nxt = '0;
        else if (w_bump && (r_glitch != '1))
            w_glitch_nxt = r_glitch + GLITCH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_LOW;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ready  <= w_ready_nxt;
            r_rise   <= w_ready_nxt & ~r_ready;
            r_fall   <= ~w_ready_nxt & r_ready;
            r_glitch <= w_glitch_nxt;
        end
    end

    assign o_ready      = r_ready;
    assign o_rise       = r_rise;
    assign o_fall       = r_fall;
    assign o_glitch_cnt = r_glitch;

endmodule
`default_nettype wire

// File: rtl/multi_ready_detector.sv
`default_nettype none
// ============================================================================
// Module      : multi_ready_detector
// Description : CHANNELS independent ready detectors sharing one clock, plus
//               an all-channels-ready summary.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               in_raw        - asynchronous ready levels, one per channel
//               clear_glitch  - zero every glitch counter
//               ready         - qualified ready per channel
//               rise / fall   - one-cycle transition pulses per channel
//               all_ready     - AND of all ready bits
//               glitch_cnt    - channel i at [i*GLITCH_W +: GLITCH_W]
// Revision    : 1.0 - initial release
// ============================================================================
module multi_ready_detector
    import ready_det_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int HIGH_CYCLES = 10000,
    parameter int LOW_CYCLES  = 1,
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          in_raw,
    input  logic                         clear_glitch,
    output logic [CHANNELS-1:0]          ready,
    output logic [CHANNELS-1:0]          rise,
    output logic [CHANNELS-1:0]          fall,
    output logic                         all_ready,
    output logic [CHANNELS*GLITCH_W-1:0] glitch_cnt
);

    localparam int CTR_SIZE = ctr_width(HIGH_CYCLES, LOW_CYCLES);

    if ((CHANNELS < 1) || (HIGH_CYCLES < 1) || (LOW_CYCLES < 1) || (GLITCH_W < 1) ||
        (SYNC_STAGES < 0)) begin : g_param_check
        $error("multi_ready_detector: illegal parameter value");
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        ready_det_channel #(
            .HIGH_CYCLES (HIGH_CYCLES),
            .LOW_CYCLES  (LOW_CYCLES),
            .SYNC_STAGES (SYNC_STAGES),
            .GLITCH_W    (GLITCH_W),
            .CTR_SIZE    (CTR_SIZE)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .i_raw          (in_raw[gi]),
            .i_clear_glitch (clear_glitch),
            .o_ready        (ready[gi]),
            .o_rise         (rise[gi]),
            .o_fall         (fall[gi]),
            .o_glitch_cnt   (glitch_cnt[gi*GLITCH_W +: GLITCH_W])
        );
    end

    assign all_ready = &ready;

endmodule
`default_nettype wire
